// File: rtl/sc_et_checkpoint.sv
// ----------------------------------------------------------------------------
// sc_et_checkpoint
//
// Early-termination monitor for a stochastic bitstream.
//
// The block counts the ones in the incoming bitstream. The upstream
// power-of-two pulse generator marks bits 1, 2, 4, ... with a checkpoint
// pulse. At each checkpoint j the block forms the normalized estimate
// E = C << (TW - j) and compares it with the estimate from the previous
// checkpoint. Evaluation stops in either of two cases:
//   - The estimate has stayed within TOL for STABLE_N consecutive
//     checkpoints, at a checkpoint index of at least MIN_K.
//   - The checkpoint at full length (j == TW) has been reached.
//
// Parameters
//   TW       log2 of the maximum stream length (full length is 2^TW bits)
//   TOL      stability tolerance, in estimate LSBs
//   STABLE_N number of consecutive stable checkpoints required (1..TW)
//   MIN_K    lowest checkpoint index at which early termination is allowed
//
// Ports
//   clk              clock
//   rst_n            asynchronous reset, active low
//   start            begin a new evaluation; clears all state
//   bit_in           stochastic bit, qualified by bit_valid
//   bit_valid        bit_in (and pulse) are valid this cycle
//   pulse            checkpoint marker on bits 1, 2, 4, ... (1-based)
//   busy             evaluation in progress
//   done             evaluation finished; held until the next start
//   terminated_early done was reached by the stability criterion
//   estimate         estimate at the last checkpoint, 0..2^TW
//   k                index of the last checkpoint
//   err              sticky pulse-placement error
//
// Optional feature: define SC_ET_CHECKPOINT_PULSE_CHECK_EN to add a shadow
// bit counter. This counter flags any pulse that does not coincide with a
// power-of-two bit number, and any such bit number that arrives without a
// pulse. When the macro is undefined, err is tied to 0.
// ----------------------------------------------------------------------------
module sc_et_checkpoint #(
    parameter int TW       = 8,
    parameter int TOL      = 1,
    parameter int STABLE_N = 2,
    parameter int MIN_K    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     pulse,
    output logic                     busy,
    output logic                     done,
    output logic                     terminated_early,
    output logic [TW:0]              estimate,
    output logic [$clog2(TW+1)-1:0]  k,
    output logic                     err
);

    localparam int KW = $clog2(TW + 1);
    localparam logic [KW-1:0]   TW_K     = KW'(TW);
    localparam logic [KW-1:0]   MIN_K_K  = KW'(MIN_K);
    localparam logic [KW-1:0]   STABLE_K = KW'(STABLE_N);
    localparam logic [TW+1:0]   TOL_U    = (TW + 2)'(TOL);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [TW:0]     cnt;         // ones seen so far
    logic [TW:0]     e_prev;      // estimate from the previous checkpoint
    logic [KW-1:0]   jcnt;        // index the next checkpoint will carry
    logic [KW-1:0]   stable_cnt;  // consecutive stable checkpoints
    logic            te_r;

    logic            cp_p0;
    logic [TW:0]     c_incl_p0;
    logic [KW-1:0]   shamt_p0;
    logic [TW:0]     e_new_p0;
    logic            stable_p0;
    logic [KW-1:0]   stab_nxt_p0;
    logic            early_p0;
    logic            full_p0;

    // Signed subtraction is done at TW+2 bits, so the difference cannot wrap.
    function automatic logic [TW+1:0] abs_diff(input logic [TW:0] a,
                                               input logic [TW:0] b);
        logic signed [TW+1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    // Saturate at STABLE_N: larger values are never needed for the decision.
    function automatic logic [KW-1:0] sat_inc(input logic [KW-1:0] s);
        return (s >= STABLE_K) ? s : s + 1'b1;
    endfunction

    // ---------------- stage 0: checkpoint evaluation (combinational) --------
    // A start in the same cycle discards the checkpoint.
    assign cp_p0       = (state == RUN) && bit_valid && pulse && !start;
    assign c_incl_p0   = cnt + {{TW{1'b0}}, bit_in};
    assign shamt_p0    = TW_K - jcnt;
    assign e_new_p0    = c_incl_p0 << shamt_p0;
    // The first checkpoint has no predecessor, so it is never stable.
    assign stable_p0   = (jcnt != '0) && (abs_diff(e_new_p0, e_prev) <= TOL_U);
    assign stab_nxt_p0 = stable_p0 ? sat_inc(stable_cnt) : '0;
    assign early_p0    = cp_p0 && (jcnt >= MIN_K_K) && (stab_nxt_p0 >= STABLE_K);
    assign full_p0     = cp_p0 && !early_p0 && (jcnt == TW_K);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (early_p0 || full_p0) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    assign terminated_early = te_r;

    // ---------------- stage 1: registered accumulator and checkpoint state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            e_prev     <= '0;
            jcnt       <= '0;
            stable_cnt <= '0;
            estimate   <= '0;
            k          <= '0;
            te_r       <= 1'b0;
        end else if (start) begin
            cnt        <= '0;
            e_prev     <= '0;
            jcnt       <= '0;
            stable_cnt <= '0;
            estimate   <= '0;
            k          <= '0;
            te_r       <= 1'b0;
        end else if (state == RUN && bit_valid) begin
            cnt <= c_incl_p0;
            if (pulse) begin
                e_prev     <= e_new_p0;
                estimate   <= e_new_p0;
                k          <= jcnt;
                jcnt       <= jcnt + 1'b1;
                stable_cnt <= stab_nxt_p0;
                if (early_p0) te_r <= 1'b1;
            end
        end
    end

`ifdef SC_ET_CHECKPOINT_PULSE_CHECK_EN
    logic [TW:0] bitcnt;
    logic [TW:0] bitcnt_incl_p0;
    logic        pulse_exp_p0;

    function automatic logic is_pow2(input logic [TW:0] x);
        return (x != '0) && ((x & (x - 1'b1)) == '0);
    endfunction

    // The shadow count includes the current bit, matching the 1-based
    // bit number the generator uses.
    assign bitcnt_incl_p0 = bitcnt + 1'b1;
    assign pulse_exp_p0   = is_pow2(bitcnt_incl_p0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= '0;
            err    <= 1'b0;
        end else if (start) begin
            bitcnt <= '0;
            err    <= 1'b0;
        end else if (state == RUN && bit_valid) begin
            bitcnt <= bitcnt_incl_p0;
            if (pulse != pulse_exp_p0) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sc_et_checkpoint.sv
module tb_sc_et_checkpoint;

    localparam int TW       = 4;
    localparam int TOL      = 1;
    localparam int STABLE_N = 2;
    localparam int MIN_K    = 2;
    localparam int KW       = $clog2(TW + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          pulse;
    logic          busy;
    logic          done;
    logic          terminated_early;
    logic [TW:0]   estimate;
    logic [KW-1:0] k;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 running, 2 done
    int m_state, m_ones, m_n, m_j, m_stab, m_eprev, m_est, m_k, m_te, m_err;
    int g_n;  // bits sent since the last start, used by the pulse generator

    sc_et_checkpoint #(.TW(TW), .TOL(TOL), .STABLE_N(STABLE_N), .MIN_K(MIN_K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .pulse(pulse), .busy(busy), .done(done),
        .terminated_early(terminated_early), .estimate(estimate), .k(k), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic bit pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_ones = 0; m_n = 0; m_j = 0; m_stab = 0;
        m_eprev = 0; m_est = 0; m_k = 0; m_te = 0; m_err = 0;
    endtask

    // Behavioural model: the estimate is the ones fraction scaled by 2^TW.
    task automatic model_step(input logic s, input logic bv, input logic bi, input logic pl);
        int e, d;
        bit stable;
        if (s) begin
            model_reset();
            m_state = 1;
        end else if (m_state == 1 && bv) begin
            m_ones += int'(bi);
            m_n++;
`ifdef SC_ET_CHECKPOINT_PULSE_CHECK_EN
            if (pl != pow2(m_n)) m_err = 1;
`endif
            if (pl) begin
                e = (m_ones * (1 << TW)) / (1 << m_j);
                e = e & ((1 << (TW + 1)) - 1);
                d = e - m_eprev;
                if (d < 0) d = -d;
                stable = (m_j > 0) && (d <= TOL);
                m_stab = stable ? m_stab + 1 : 0;
                m_eprev = e;
                m_est = e;
                m_k = m_j;
                if (m_j >= MIN_K && m_stab >= STABLE_N) begin
                    m_state = 2; m_te = 1;
                end else if (m_j == TW) begin
                    m_state = 2;
                end
                m_j++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("busy", 32'(busy), 32'(m_state == 1));
        check("done", 32'(done), 32'(m_state == 2));
        check("terminated_early", 32'(terminated_early), 32'(m_te));
        check("estimate", 32'(estimate), 32'(m_est));
        check("k", 32'(k), 32'(m_k));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic drive(input logic s, input logic bv, input logic bi, input logic pl);
        start = s; bit_valid = bv; bit_in = bi; pulse = pl;
        @(posedge clk);
        model_step(s, bv, bi, pl);
        #1;
        compare_all();
    endtask

    task automatic do_start();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        g_n = 0;
    endtask

    // Optional idle gap (sometimes carrying a stray pulse), then one valid bit.
    task automatic send_bit(input logic bi, input bit gaps, input bit inject);
        logic pl;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0)
                drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        pl = pow2(g_n + 1) || inject;
        drive(1'b0, 1'b1, bi, pl);
        g_n++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; pulse = 1'b0;
        g_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Bits before any start are ignored
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);

        // All-ones stream
        do_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
        check("ones_done", 32'(done), 32'd1);
        check("ones_te", 32'(terminated_early), 32'd1);
        check("ones_est", 32'(estimate), 32'd16);
        check("ones_k", 32'(k), 32'd2);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("ones_hold_est", 32'(estimate), 32'd16);

        // Alternating 1,0,1,0,...
        do_start();
        for (int i = 0; i < 8; i++) send_bit(1'(i % 2 == 0), 1'b1, 1'b0);
        check("alt_done", 32'(done), 32'd1);
        check("alt_te", 32'(terminated_early), 32'd1);
        check("alt_est", 32'(estimate), 32'd8);
        check("alt_k", 32'(k), 32'd3);

        // Never-stable stream, runs to full length
        do_start();
        for (int i = 0; i < 16; i++) send_bit(1'(i == 0 || (i >= 4 && i < 8)), 1'b1, 1'b0);
        check("full_done", 32'(done), 32'd1);
        check("full_te", 32'(terminated_early), 32'd0);
        check("full_est", 32'(estimate), 32'd5);
        check("full_k", 32'(k), 32'd4);

        // Restart mid-run at bit 6; the bit under start is dropped
        do_start();
        for (int i = 0; i < 5; i++) send_bit(1'(i == 0 || i == 4), 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        g_n = 0;
        check("restart_est_cleared", 32'(estimate), 32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
        check("restart_done", 32'(done), 32'd1);
        check("restart_te", 32'(terminated_early), 32'd1);
        check("restart_est", 32'(estimate), 32'd16);
        check("restart_k", 32'(k), 32'd2);

        // Random streams with random gaps
        for (int s = 0; s < 8; s++) begin
            do_start();
            for (int i = 0; i < 16 && m_state == 1; i++)
                send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            check("rand_done", 32'(done), 32'd1);
        end

        // Asynchronous reset in the middle of a run
        do_start();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pulse injected on bit 3
        do_start();
        for (int i = 0; i < 16 && m_state == 1; i++)
            send_bit(1'b0, 1'b0, (g_n + 1 == 3));
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SC_ET_CHECKPOINT_PULSE_CHECK_EN
        check("err_sticky", 32'(err), 32'd1);
`else
        check("err_tied", 32'(err), 32'd0);
`endif
        do_start();
        check("err_cleared", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_et_checkpoint.md
# sc_et_checkpoint

Consumer side of the power-of-two checkpoint pulse used for stochastic-computing early termination. It accumulates the ones in an incoming stochastic bitstream. At every checkpoint pulse, which marks bit 2^j, it forms a normalized estimate and compares it with the estimate from the previous checkpoint. It declares termination once the estimate has been stable for enough consecutive checkpoints, or when the full stream length is reached. It sits downstream of the SC datapath, next to the pow2 pulse generator driven from the same bit-valid clock enable.

## Interface
Parameters:
- TW, 8: log2 of maximum stream length; full length is 2^TW bits.
- TOL, 1: stability tolerance in estimate LSBs (estimate is a fraction scaled by 2^TW).
- STABLE_N, 2: consecutive stable checkpoints required; range 1..TW.
- MIN_K, 2: lowest checkpoint index at which early termination is allowed.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin a new evaluation; clears all state.
- bit_in, in, 1: stochastic bit, qualified by bit_valid.
- bit_valid, in, 1: bit_in is valid this cycle.
- pulse, in, 1: checkpoint marker, high on bits numbered 1, 2, 4, … (1-based); qualified by bit_valid.
- busy, out, 1: evaluation in progress.
- done, out, 1: evaluation finished; level-held until the next start.
- terminated_early, out, 1: done was reached by the stability criterion.
- estimate, out, TW+1: last checkpoint estimate, range 0..2^TW.
- k, out, $clog2(TW+1): index j of the last checkpoint.
- err, out, 1: sticky pulse-placement error.

## Operation
- States: IDLE, RUN, DONE. Reset places the block in IDLE and drives every output to 0.
- On start, in any state: enter RUN and clear the ones count C, bit count, j, stable_cnt, estimate, E_prev, done, terminated_early and err.
- In RUN, on each bit_valid: C += bit_in (C is TW+1 bits) and the bit count increments.
- A checkpoint is a cycle where bit_valid && pulse, and it includes the current bit.
  - E_new = C_incl << (TW − j), where j is the checkpoint index (first pulse is j = 0).
  - Stable if |E_new − E_prev| ≤ TOL. At j = 0 the result is always unstable, because there is no prior estimate.
  - If stable, stable_cnt++ (saturating); otherwise stable_cnt = 0.
  - Update E_prev, estimate and k to the new values.
  - If j ≥ MIN_K and the updated stable_cnt ≥ STABLE_N: go to DONE with terminated_early = 1.
  - Else if j == TW: go to DONE with terminated_early = 0. Full-length checks run after the stability check.
- Ignored inputs:
  - pulse without bit_valid.
  - bit_valid in IDLE or DONE.
  - start while start is already being processed in the same cycle; this simply restarts.
- DONE holds estimate, k, done and terminated_early stable until the next start or reset.
- Arithmetic:
  - Subtraction is done at TW+2 bits signed, so it cannot wrap.
  - C never exceeds 2^TW, because termination is forced at j = TW.

## Timing
- start sampled at edge n: busy = 1 from n+1. A bit_valid in the same cycle as start is dropped.
- Checkpoint sampled at edge n: estimate and k update at n+1. done, terminated_early and busy = 0 also take effect at n+1 when the termination condition is met.
- Throughput: one bit per cycle; bit_valid may be gapped arbitrarily.
- Asynchronous reset mid-run returns the block to IDLE immediately, with all outputs 0.
- Simultaneous start and checkpoint: start wins and the checkpoint is discarded.

## Configuration
- SC_ET_CHECKPOINT_PULSE_CHECK_EN defined:
  - A shadow check in RUN compares pulse against (bit count incl. current) being a power of two, on every bit_valid cycle.
  - Any mismatch, whether a missing or a spurious pulse, sets err at the next edge. err stays set until start or reset.
- Not defined: err is tied to 0 and no shadow logic exists. Operation is otherwise identical.

## Test plan
TW=4, TOL=1, STABLE_N=2, MIN_K=2, with pulses from a correct pow2 generator unless stated otherwise.
- Reset → all outputs 0, IDLE. Bits presented before start → no change.
- All-ones stream after start → checkpoints E = 16, 16, 16. done at bit 4 with terminated_early = 1, estimate = 16, k = 2.
- Stream 1,0,1,0,… → E = 16, 8, 8, 8. done after bit 8 with terminated_early = 1, estimate = 8, k = 3.
- Stream bits 1 = 1, 2–4 = 0, 5–8 = 1, 9–16 = 0 → E = 16, 8, 4, 10, 5, never stable. done after bit 16 with terminated_early = 0, estimate = 5, k = 4.
- Random bit_valid gaps, stray pulse with bit_valid = 0, and start asserted mid-run at bit 6 → the stray pulse is ignored. The restart clears state, and the all-ones result matches the second bullet counted from the restart.
- Pulse injected at bit 3 → err = 1 one cycle later and stays sticky with the macro defined; err stays 0 without it.
